// File: rtl/trap_ctrl.sv
// trap_ctrl
//   Machine-mode trap controller. It arbitrates synchronous exceptions,
//   masked interrupt lines and mret, and runs a flush handshake with the
//   pipeline. It then commits CSR write data and a PC redirect in a single
//   cycle. The current privilege level is owned here.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   exc_en/code/val     synchronous exception request, cause and mtval value
//   irq_pending/enable  level interrupt lines and per-line mie mask
//   mret                mret retiring
//   pc_addr             PC of the faulting or interrupted instruction
//   mtvec               trap vector base; [1:0] selects the mode
//   mepc_current        mepc read from the CSR file
//   mstatus_current     mstatus read from the CSR file
//   flush_ack           pipeline has drained
//   flush_req           request pipeline flush
//   trap_busy           controller is not idle
//   redirect_valid/pc   one-cycle redirect pulse and its target
//   csr_we, *_wdata     one-cycle CSR write strobe and write data
//   priv_lvl            current privilege level
//   is_trap             redirect is a trap entry (1) or an mret (0)
//
// state  | meaning
// -------+-------------------------------------------------------
// IDLE   | waiting for exception / interrupt / mret
// FLUSH  | request latched, flush_req high until flush_ack
// COMMIT | one cycle: CSR write strobe and redirect pulse

module trap_ctrl #(
   parameter int          XLEN       = 64,
   parameter int          NUM_IRQ    = 16,
   parameter int          CAUSE_W    = 5,
   parameter logic [1:0]  RESET_PRIV = 2'b11
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               exc_en,
   input  logic [CAUSE_W-1:0] exc_code,
   input  logic [XLEN-1:0]    exc_val,
   input  logic [NUM_IRQ-1:0] irq_pending,
   input  logic [NUM_IRQ-1:0] irq_enable,
   input  logic               mret,
   input  logic [XLEN-1:0]    pc_addr,
   input  logic [XLEN-1:0]    mtvec,
   input  logic [XLEN-1:0]    mepc_current,
   input  logic [XLEN-1:0]    mstatus_current,
   input  logic               flush_ack,
   output logic               flush_req,
   output logic               trap_busy,
   output logic               redirect_valid,
   output logic [XLEN-1:0]    redirect_pc,
   output logic               csr_we,
   output logic [XLEN-1:0]    mepc_wdata,
   output logic [XLEN-1:0]    mcause_wdata,
   output logic [XLEN-1:0]    mtval_wdata,
   output logic [XLEN-1:0]    mstatus_wdata,
   output logic [1:0]         priv_lvl,
   output logic               is_trap
);

   typedef enum logic [1:0] {S_IDLE, S_FLUSH, S_COMMIT} state_t;
   typedef enum logic [1:0] {K_EXC, K_IRQ, K_MRET}      kind_t;

   state_t state, state_nxt;

   kind_t               kind_q;
   logic [CAUSE_W-1:0]  code_q;
   logic [XLEN-1:0]     tval_q;
   logic [XLEN-1:0]     pc_q;

   logic [XLEN-1:0]     mepc_q, mcause_q, mtval_q, mstatus_q, rpc_q;
   logic                is_trap_q;

   logic [NUM_IRQ-1:0]  irq_masked;
   logic                irq_req;
   logic [CAUSE_W-1:0]  irq_sel;
   logic                accept;
   logic                commit;

   logic [XLEN-1:0]     tvec_base, code_ext, trap_pc;
   logic [XLEN-1:0]     mepc_c, mcause_c, mtval_c, mstatus_c, rpc_c;
   logic [XLEN-1:0]     mstatus_trap, mstatus_ret;

   // Interrupt eligibility: M-mode only takes interrupts with MIE set.
   assign irq_masked = irq_pending & irq_enable;
   assign irq_req    = ((priv_lvl != 2'b11) | mstatus_current[3]) & (|irq_masked);

   // Ascending scan so the highest set index is the last one written.
   always_comb begin
      irq_sel = '0;
      for (int i = 0; i < NUM_IRQ; i++) begin
         if (irq_masked[i]) irq_sel = CAUSE_W'(i);
      end
   end

   assign accept = (state == S_IDLE) & (exc_en | irq_req | mret);
   assign commit = (state == S_COMMIT);

   always_comb begin
      state_nxt = state;
      flush_req = 1'b0;
      case (state)
         S_IDLE:   if (accept) state_nxt = S_FLUSH;
         S_FLUSH: begin
            flush_req = 1'b1;
            if (flush_ack) state_nxt = S_COMMIT;
         end
         S_COMMIT: state_nxt = S_IDLE;
         default:  state_nxt = S_IDLE;
      endcase
   end

   assign trap_busy = (state != S_IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         kind_q <= K_EXC;
         code_q <= '0;
         tval_q <= '0;
         pc_q   <= '0;
      end else if (accept) begin
         pc_q <= {pc_addr[XLEN-1:1], 1'b0};
         if (exc_en) begin
            kind_q <= K_EXC;
            code_q <= exc_code;
            tval_q <= exc_val;
         end else if (irq_req) begin
            kind_q <= K_IRQ;
            code_q <= irq_sel;
            tval_q <= '0;
         end else begin
            kind_q <= K_MRET;
            code_q <= '0;
            tval_q <= '0;
         end
      end
   end

   // Commit-cycle values. mstatus_current is used as seen in COMMIT so that
   // CSR writes landing during the flush are not lost.
   assign tvec_base = {mtvec[XLEN-1:2], 2'b00};
   assign code_ext  = {{(XLEN-CAUSE_W){1'b0}}, code_q};
   assign trap_pc   = ((mtvec[1:0] == 2'b01) && (kind_q == K_IRQ))
                      ? tvec_base + (code_ext << 2) : tvec_base;

   always_comb begin
      mstatus_trap        = mstatus_current;
      mstatus_trap[7]     = mstatus_current[3];
      mstatus_trap[3]     = 1'b0;
      mstatus_trap[12:11] = priv_lvl;

      mstatus_ret         = mstatus_current;
      mstatus_ret[3]      = mstatus_current[7];
      mstatus_ret[7]      = 1'b1;
      mstatus_ret[12:11]  = 2'b00;
   end

   always_comb begin
      if (kind_q == K_MRET) begin
         mepc_c    = mepc_q;
         mcause_c  = mcause_q;
         mtval_c   = mtval_q;
         mstatus_c = mstatus_ret;
         rpc_c     = {mepc_current[XLEN-1:1], 1'b0};
      end else begin
         mepc_c    = pc_q;
         mcause_c  = {(kind_q == K_IRQ), {(XLEN-1-CAUSE_W){1'b0}}, code_q};
         mtval_c   = tval_q;
         mstatus_c = mstatus_trap;
         rpc_c     = trap_pc;
      end
   end

   // Data outputs show the commit values during COMMIT and hold them after.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mepc_q    <= '0;
         mcause_q  <= '0;
         mtval_q   <= '0;
         mstatus_q <= '0;
         rpc_q     <= '0;
         is_trap_q <= 1'b0;
         priv_lvl  <= RESET_PRIV;
      end else if (commit) begin
         mepc_q    <= mepc_c;
         mcause_q  <= mcause_c;
         mtval_q   <= mtval_c;
         mstatus_q <= mstatus_c;
         rpc_q     <= rpc_c;
         is_trap_q <= (kind_q != K_MRET);
         priv_lvl  <= (kind_q == K_MRET) ? mstatus_current[12:11] : 2'b11;
      end
   end

   assign redirect_valid = commit;
   assign csr_we         = commit;
   assign mepc_wdata     = commit ? mepc_c    : mepc_q;
   assign mcause_wdata   = commit ? mcause_c  : mcause_q;
   assign mtval_wdata    = commit ? mtval_c   : mtval_q;
   assign mstatus_wdata  = commit ? mstatus_c : mstatus_q;
   assign redirect_pc    = commit ? rpc_c     : rpc_q;
   assign is_trap        = commit ? (kind_q != K_MRET) : is_trap_q;

endmodule

// File: tb/tb_trap_ctrl.sv
module tb_trap_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        exc_en;
   logic [4:0]  exc_code;
   logic [63:0] exc_val;
   logic [15:0] irq_pending, irq_enable;
   logic        mret;
   logic [63:0] pc_addr, mtvec, mepc_current, mstatus_current;
   logic        flush_ack;
   logic        flush_req, trap_busy, redirect_valid, csr_we, is_trap;
   logic [63:0] redirect_pc, mepc_wdata, mcause_wdata, mtval_wdata, mstatus_wdata;
   logic [1:0]  priv_lvl;

   int total = 0;
   int bad   = 0;

   trap_ctrl dut (
      .clk(clk), .rst_n(rst_n),
      .exc_en(exc_en), .exc_code(exc_code), .exc_val(exc_val),
      .irq_pending(irq_pending), .irq_enable(irq_enable), .mret(mret),
      .pc_addr(pc_addr), .mtvec(mtvec), .mepc_current(mepc_current),
      .mstatus_current(mstatus_current), .flush_ack(flush_ack),
      .flush_req(flush_req), .trap_busy(trap_busy),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .csr_we(csr_we), .mepc_wdata(mepc_wdata), .mcause_wdata(mcause_wdata),
      .mtval_wdata(mtval_wdata), .mstatus_wdata(mstatus_wdata),
      .priv_lvl(priv_lvl), .is_trap(is_trap)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- behavioural reference model ----------------
   // kind: 0 exception, 1 interrupt, 2 mret
   typedef struct packed {
      logic        vld;
      logic [1:0]  kind;
      logic [4:0]  code;
      logic [63:0] tval;
      logic [63:0] pc;
   } txn_t;

   typedef struct packed {
      logic [63:0] mepc, mcause, mtval, mstat, rpc;
      logic        trap;
   } res_t;

   int          m_phase;   // 0 waiting for request, 1 flushing, 2 committing
   txn_t        m_t;
   logic [1:0]  m_priv;
   res_t        m_h;       // values last committed

   function automatic txn_t pick();
      txn_t t = '0;
      logic [15:0] m = irq_pending & irq_enable;
      bit   ie = (m_priv != 2'b11) || mstatus_current[3];
      t.pc = pc_addr & ~64'h1;
      if (exc_en) begin
         t.vld = 1; t.kind = 0; t.code = exc_code; t.tval = exc_val;
      end else if (ie && m != 0) begin
         t.vld = 1; t.kind = 1;
         for (int i = 15; i >= 0; i--)
            if (m[i] && !t.code[4]) begin t.code = 5'(i); t.code[4] = 1'b1; end
         t.code[4] = 1'b0;  // flag bit reused while searching; lines fit in 4 bits
      end else if (mret) begin
         t.vld = 1; t.kind = 2;
      end
      return t;
   endfunction

   function automatic res_t commit_of(txn_t t, logic [1:0] prv, res_t h);
      res_t r = h;
      logic [63:0] base = mtvec & ~64'h3;
      r.mstat = mstatus_current;
      if (t.kind == 2) begin
         r.mstat[3]     = mstatus_current[7];
         r.mstat[7]     = 1'b1;
         r.mstat[12:11] = 2'b00;
         r.rpc  = mepc_current & ~64'h1;
         r.trap = 1'b0;
      end else begin
         r.mstat[7]     = mstatus_current[3];
         r.mstat[3]     = 1'b0;
         r.mstat[12:11] = prv;
         r.mepc   = t.pc;
         r.mcause = (t.kind == 1 ? 64'h8000_0000_0000_0000 : 64'h0) + 64'(t.code);
         r.mtval  = (t.kind == 1) ? 64'h0 : t.tval;
         r.rpc    = (t.kind == 1 && mtvec[1:0] == 2'b01) ? base + 64'(t.code) * 4 : base;
         r.trap   = 1'b1;
      end
      return r;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_phase <= 0;
         m_t     <= '0;
         m_priv  <= 2'b11;
         m_h     <= '0;
      end else if (m_phase == 0) begin
         if (pick().vld) begin
            m_t     <= pick();
            m_phase <= 1;
         end
      end else if (m_phase == 1) begin
         if (flush_ack) m_phase <= 2;
      end else begin
         m_h     <= commit_of(m_t, m_priv, m_h);
         m_priv  <= (m_t.kind == 2) ? mstatus_current[12:11] : 2'b11;
         m_phase <= 0;
      end
   end

   bit check_en = 0;

   always @(negedge clk) begin
      if (rst_n && check_en) begin
         res_t e;
         e = (m_phase == 2) ? commit_of(m_t, m_priv, m_h) : m_h;
         chk("flush_req",      64'(flush_req),      64'(m_phase == 1));
         chk("trap_busy",      64'(trap_busy),      64'(m_phase != 0));
         chk("redirect_valid", 64'(redirect_valid), 64'(m_phase == 2));
         chk("csr_we",         64'(csr_we),         64'(m_phase == 2));
         chk("priv_lvl",       64'(priv_lvl),       64'(m_priv));
         chk("redirect_pc",    redirect_pc,         e.rpc);
         chk("mepc_wdata",     mepc_wdata,          e.mepc);
         chk("mcause_wdata",   mcause_wdata,        e.mcause);
         chk("mtval_wdata",    mtval_wdata,         e.mtval);
         chk("mstatus_wdata",  mstatus_wdata,       e.mstat);
         chk("is_trap",        64'(is_trap),        64'(e.trap));
      end
   end

   // ---------------- directed helpers ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Leaves the caller at the negedge of the COMMIT cycle when found.
   task automatic wait_redirect(input string nm);
      bit ok = 0;
      for (int i = 0; i < 20 && !ok; i++) begin
         @(negedge clk);
         if (redirect_valid) ok = 1;
      end
      chk({nm, "_redirect_seen"}, 64'(ok), 64'h1);
   endtask

   task automatic do_mret(input logic [63:0] ms, input logic [63:0] epc);
      mstatus_current = ms; mepc_current = epc; mret = 1'b1;
      step();
      mret = 1'b0;
   endtask

   initial begin
      rst_n = 0; exc_en = 0; exc_code = 0; exc_val = 0;
      irq_pending = 0; irq_enable = 0; mret = 0; pc_addr = 0;
      mtvec = 0; mepc_current = 0; mstatus_current = 0; flush_ack = 1;
      repeat (3) step();
      rst_n = 1;
      @(negedge clk);
      chk("rst_priv",   64'(priv_lvl), 64'h3);
      chk("rst_busy",   64'(trap_busy), 64'h0);
      chk("rst_rpc",    redirect_pc, 64'h0);
      chk("rst_mstat",  mstatus_wdata, 64'h0);
      check_en = 1;
      step();

      // mret back to M-mode, then to U-mode
      do_mret(64'h1880, 64'h3003);
      wait_redirect("mret1");
      chk("mret1_rpc",   redirect_pc, 64'h3002);
      chk("mret1_trap",  64'(is_trap), 64'h0);
      chk("mret1_mstat", mstatus_wdata, 64'h0088);
      step();
      chk("mret1_priv",  64'(priv_lvl), 64'h3);
      do_mret(64'h0080, 64'h3003);
      wait_redirect("mret2");
      step();
      chk("mret2_priv",  64'(priv_lvl), 64'h0);

      // exception, direct mode, flush_ack after three cycles of flush_req
      mstatus_current = 64'h8; exc_en = 1; exc_code = 5'd2; exc_val = 64'hDEAD;
      pc_addr = 64'h1001; mtvec = 64'h100; flush_ack = 0;
      step();
      exc_en = 0;
      for (int k = 0; k < 3; k++) begin
         if (k == 2) flush_ack = 1;
         @(negedge clk);
         chk("exc_flush_req", 64'(flush_req), 64'h1);
         step();
      end
      @(negedge clk);
      chk("exc_commit",  64'(redirect_valid), 64'h1);
      chk("exc_mepc",    mepc_wdata,    64'h1000);
      chk("exc_mcause",  mcause_wdata,  64'h2);
      chk("exc_mtval",   mtval_wdata,   64'hDEAD);
      chk("exc_mstat",   mstatus_wdata, 64'h80);
      chk("exc_rpc",     redirect_pc,   64'h100);
      step();
      chk("exc_priv",    64'(priv_lvl), 64'h3);

      // masking in M-mode with MIE=0, then unmasked by dropping to U-mode
      mstatus_current = 64'h0; irq_pending = 16'h0020; irq_enable = 16'hFFFF;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("mask_busy", 64'(trap_busy), 64'h0);
         step();
      end
      do_mret(64'h0, 64'h0);
      wait_redirect("mask_mret");
      step();
      wait_redirect("mask_irq");
      chk("mask_mcause", mcause_wdata, 64'h8000_0000_0000_0005);
      chk("mask_trap",   64'(is_trap), 64'h1);
      step();
      irq_pending = 0;

      // vectored interrupt, highest pending line wins
      mstatus_current = 64'h8; mtvec = 64'h201; irq_pending = 16'h0088;
      step();
      wait_redirect("vec");
      chk("vec_mcause", mcause_wdata, 64'h8000_0000_0000_0007);
      chk("vec_rpc",    redirect_pc,  64'h21C);
      chk("vec_mtval",  mtval_wdata,  64'h0);
      step();
      irq_pending = 0;

      // simultaneous requests; exception wins, new exc_en during FLUSH ignored
      irq_pending = 16'h0004; mret = 1; exc_en = 1; exc_code = 5'd11; flush_ack = 0;
      step();
      mret = 0; irq_pending = 0; exc_code = 5'd4;
      step(); step();
      exc_en = 0; flush_ack = 1;
      wait_redirect("arb");
      chk("arb_mcause", mcause_wdata, 64'hB);
      chk("arb_trap",   64'(is_trap), 64'h1);
      step();
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("arb_idle", 64'(trap_busy), 64'h0);
         step();
      end

      // asynchronous reset in the middle of FLUSH, from U-mode
      do_mret(64'h0, 64'h0);
      wait_redirect("rst_prep");
      step();
      exc_en = 1; flush_ack = 0;
      step();
      exc_en = 0;
      @(negedge clk);
      chk("rst_pre_flush", 64'(flush_req), 64'h1);
      #2 rst_n = 0;
      #1;
      chk("rst_async_flush", 64'(flush_req), 64'h0);
      chk("rst_async_busy",  64'(trap_busy), 64'h0);
      chk("rst_async_priv",  64'(priv_lvl),  64'h3);
      step();
      rst_n = 1; flush_ack = 1;
      @(negedge clk);
      chk("rst_rel_mcause", mcause_wdata, 64'h0);
      chk("rst_rel_busy",   64'(trap_busy), 64'h0);
      step();

      // randomized traffic against the model
      for (int c = 0; c < 3000; c++) begin
         exc_en          = ($urandom_range(0, 9) == 0);
         exc_code        = 5'($urandom);
         exc_val         = {$urandom, $urandom};
         mret            = ($urandom_range(0, 7) == 0);
         irq_pending     = ($urandom_range(0, 3) == 0) ? 16'(1 << $urandom_range(0, 15)) |
                           16'(1 << $urandom_range(0, 15)) : 16'h0;
         irq_enable      = 16'($urandom);
         pc_addr         = {$urandom, $urandom};
         mtvec           = {$urandom, $urandom};
         mepc_current    = {$urandom, $urandom};
         mstatus_current = {$urandom, $urandom};
         flush_ack       = ($urandom_range(0, 4) < 3);
         step();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
